mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single DDR2 memory command port (valid/rw/addr/wdata -> ready/rdata) between two
//  cache-side requesters (req0 = I-cache, req1 = D-cache). Round-robin arbitration, one
//  outstanding transaction, command held to the memory side until mem_ready_data.
//  Sticky error flags cover timeout, requester abandon and spurious ready.
// PARAMETERS
//  ADDR_W   28    command address width
//  DATA_W   32    read/write data width
//  TIMEOUT  1023  cycles in GRANT without mem_ready_data before error[0] sets
//  TO_W     10    timeout counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk             in   1       single clock, posedge
//  rst             in   1       asynchronous, active-low reset
//  req0_valid      in   1       req0 command valid; held until req0_ready
//  req0_rw         in   1       1 = write, 0 = read
//  req0_addr       in   ADDR_W  req0 address
//  req0_wdata      in   DATA_W  req0 write data
//  req0_ready      out  1       1-cycle completion pulse to req0
//  req0_rdata      out  DATA_W  read data; valid only while req0_ready=1
//  req1_*          (same six signals for req1)
//  mem_valid_data  out  1       command valid to memory controller
//  mem_rw_data     out  1       1 = write, 0 = read
//  mem_data_addr   out  ADDR_W  address to memory controller
//  mem_data_wr     out  DATA_W  write data to memory controller
//  mem_data_rd     in   DATA_W  read data from memory controller
//  mem_ready_data  in   1       completion pulse from memory controller
//  err_clr         in   1       synchronous clear of error[2:0]
//  error           out  3       sticky: [0] timeout, [1] abandon, [2] spurious ready
//  busy            out  1       1 while in GRANT0/GRANT1
//  grant_id        out  1       requester currently or last granted
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; rr_ptr=0 (req0 preferred); timeout count=0.
//   error=0, grant_id=0, busy=0. mem_valid_data, mem_rw_data, req*_ready = 0.
//   Mid-transaction reset drops the command. No replay.
//  FSM states: IDLE, GRANT0, GRANT1.
//   IDLE, exactly one valid        -> GRANT of that requester.
//   IDLE, both valid               -> GRANT of the one not last granted (rr_ptr); rr_ptr flips.
//   GRANTx, mem_ready_data=1       -> IDLE.
//  Command path:
//   mem_valid_data = busy, registered from state, so it cannot glitch.
//   mem_rw_data/mem_data_addr/mem_data_wr mux from granted req; all 0 in IDLE.
//  Latency:
//   Request sampled in IDLE at cycle A -> mem_valid_data=1 from cycle A+1.
//   mem_ready_data at cycle B (B>=A+1) -> reqx_ready=1 and reqx_rdata=mem_data_rd in cycle B,
//    combinational pass-through. Non-granted ready stays 0 and its rdata is 0.
//   Cycle B+1 is IDLE, one turnaround cycle. Next grant is evaluated in B+1, new mem_valid in B+2.
//   A requester valid still high in B+1 is a NEW command.
//   Lone requester may be granted back to back.
//  Timeout:
//   Counter clears on entry to GRANT and increments each GRANT cycle, saturating at TIMEOUT.
//   Reaching TIMEOUT sets error[0]. No abort: the transaction keeps waiting.
//  Abandon: granted reqx_valid=0 while in GRANT and before ready -> error[1].
//   Command stays asserted (muxed values as driven). Transaction still completes.
//  Spurious: mem_ready_data=1 in IDLE -> error[2]; ignored otherwise.
//  err_clr has priority over a same-cycle set. Flags clear, then re-set next cycle if the condition persists.
//  Starvation bound: with both requesters always valid, grants alternate strictly 0,1,0,1...
// STRUCTURE
//  Shared package mem_arb_pkg: state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2),
//   error bit indices (ERR_TIMEOUT=0, ERR_ABANDON=1, ERR_SPURIOUS=2).
//  One sub-module: mem_arb_rr_pick.
//   Purely combinational 2-way round-robin select: valids + rr_ptr -> grant_valid, grant_idx.
//  FSM, timeout counter, muxes and error regs stay in the top.
// TESTING
//  1 Reset with both valid high -> all outputs 0; first grant after rst release is req0.
//  2 req0 write addr=28'h0000010 wdata=32'hA5A5A5A5, ready after 5 cycles
//    -> mem_valid high cycles A+1..A+5, mem_rw=1, req0_ready pulses once, then 1 idle cycle.
//  3 Both valid continuously, reads, ready 2 cycles after each mem_valid
//    -> grant_id sequence 0,1,0,1; req1_rdata=mem_data_rd=32'h12345678 in its ready cycle.
//  4 TIMEOUT=8, no ready -> error=3'b001 after 8 GRANT cycles, mem_valid stays high;
//    late ready completes normally; err_clr -> error=0.
//  5 req1 drops valid mid-GRANT -> error[1]=1; mem_ready_data in IDLE -> error[2]=1; both sticky.
//  6 Assert rst low mid-GRANT1 -> mem_valid_data=0 immediately; state IDLE; rr_ptr back to req0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester DDR2 command-port arbiter:
// FSM state encoding and sticky error bit positions.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    localparam int ERR_W        = 3;
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_ABANDON  = 1;
    localparam int ERR_SPURIOUS = 2;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin select. rr_ptr_i names the requester that
// wins when both are valid; a lone valid requester always wins.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_valid_o = |valid_i;
        grant_idx_o   = (&valid_i) ? rr_ptr_i : valid_i[1];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one DDR2 command port between I-cache (req0) and D-cache (req1):
// round-robin grant, one outstanding command, sticky error flags.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_valid_data,
    output logic              mem_rw_data,
    output logic [ADDR_W-1:0] mem_data_addr,
    output logic [DATA_W-1:0] mem_data_wr,
    input  logic [DATA_W-1:0] mem_data_rd,
    input  logic              mem_ready_data,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  error,
    output logic              busy,
    output logic              grant_id
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    arb_state_e       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             grant_id_q, grant_id_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0] error_q, error_d;
    logic [ERR_W-1:0] err_set;

    logic             pick_valid;
    logic             pick_idx;
    logic             sel1;
    logic             gnt_valid;

    mem_arb_rr_pick u_pick (
        .valid_i       ({req1_valid, req0_valid}),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (pick_valid),
        .grant_idx_o   (pick_idx)
    );

    assign sel1      = (state_q == GRANT1);
    assign gnt_valid = sel1 ? req1_valid : req0_valid;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        err_set    = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d    = pick_idx ? GRANT1 : GRANT0;
                    grant_id_d = pick_idx;
                    // The pointer only moves when there was actually a contest.
                    if (req0_valid && req1_valid) rr_ptr_d = ~rr_ptr_q;
                end
                if (mem_ready_data) err_set[ERR_SPURIOUS] = 1'b1;
            end
            GRANT0, GRANT1: begin
                if (cnt_q != TO_MAX) cnt_d = cnt_q + TO_W'(1);
                if (mem_ready_data) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_d == TO_MAX) err_set[ERR_TIMEOUT] = 1'b1;
                    if (!gnt_valid)      err_set[ERR_ABANDON] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        error_d = err_clr ? '0 : (error_q | err_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            grant_id_q <= 1'b0;
            cnt_q      <= '0;
            error_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
        end
    end

    // Command valid is a pure decode of the state register, so it cannot glitch.
    always_comb begin
        busy           = (state_q != IDLE);
        mem_valid_data = busy;
        mem_rw_data    = busy & (sel1 ? req1_rw : req0_rw);
        mem_data_addr  = busy ? (sel1 ? req1_addr : req0_addr) : '0;
        mem_data_wr    = busy ? (sel1 ? req1_wdata : req0_wdata) : '0;
        req0_ready     = (state_q == GRANT0) & mem_ready_data;
        req1_ready     = (state_q == GRANT1) & mem_ready_data;
        req0_rdata     = req0_ready ? mem_data_rd : '0;
        req1_rdata     = req1_ready ? mem_data_rd : '0;
        error          = error_q;
        grant_id       = grant_id_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them against req*_ready pulses.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int W      = DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_rw, req1_valid, req1_rw;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_rdata, req1_rdata;
    logic              mem_valid_data, mem_rw_data;
    logic [ADDR_W-1:0] mem_data_addr;
    logic [DATA_W-1:0] mem_data_wr, mem_data_rd;
    logic              mem_ready_data, err_clr;
    logic [2:0]        error;
    logic              busy, grant_id;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8), .TO_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .mem_valid_data(mem_valid_data), .mem_rw_data(mem_rw_data),
        .mem_data_addr(mem_data_addr), .mem_data_wr(mem_data_wr),
        .mem_data_rd(mem_data_rd), .mem_ready_data(mem_ready_data),
        .err_clr(err_clr), .error(error), .busy(busy), .grant_id(grant_id)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_rw = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_rw = 0; req1_addr = '0; req1_wdata = '0;
        mem_data_rd = '0; mem_ready_data = 0; err_clr = 0;
    endtask

    task automatic reset_dut();
        rst = 0;
        idle_inputs();
        cyc();
        cyc();
        rst = 1;
        cyc();
    endtask

    // Called in the ready cycle; returns one cycle later (turnaround IDLE).
    task automatic finish_txn(input logic idx, input logic [DATA_W-1:0] rd);
        mem_ready_data = 1;
        mem_data_rd    = rd;
        exp_q.push_back({idx, rd});
        mid();
        cyc();
        mem_ready_data = 0;
        mem_data_rd    = '0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && (req0_ready || req1_ready)) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL sb_unexpected: req0_ready=%0b req1_ready=%0b with nothing expected (t=%0t)",
                         req0_ready, req1_ready, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_one_ready", req0_ready & req1_ready, 0);
                check("sb_idx", req1_ready, mon_e[W-1]);
                check("sb_req0_rdata", req0_rdata, mon_e[W-1] ? 32'h0 : mon_e[DATA_W-1:0]);
                check("sb_req1_rdata", req1_rdata, mon_e[W-1] ? mon_e[DATA_W-1:0] : 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requesters valid.
        rst = 0;
        idle_inputs();
        req0_valid = 1; req0_rw = 1; req0_addr = 28'h0000AAA;
        req1_valid = 1; req1_addr = 28'h0000BBB;
        mid();
        check("rst_mem_valid", mem_valid_data, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_error", error, 3'b000);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_mem_rw", mem_rw_data, 0);
        check("rst_mem_addr", mem_data_addr, 28'h0);
        cyc();
        rst = 1;
        mid();
        check("rel_idle", busy, 0);
        cyc();
        mid();
        check("first_grant_busy", busy, 1);
        check("first_grant_id", grant_id, 0);
        check("first_grant_addr", mem_data_addr, 28'h0000AAA);
        cyc();
        finish_txn(0, 32'hFEEDBEEF);
        req0_valid = 0; req1_valid = 0;
        mid();

        // Single write, ready five cycles after the request is sampled.
        reset_dut();
        req0_valid = 1; req0_rw = 1; req0_addr = 28'h0000010; req0_wdata = 32'hA5A5A5A5;
        mid();
        check("wr_cycA_mem_valid", mem_valid_data, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            mid();
            check("wr_mem_valid", mem_valid_data, 1);
            if (k == 1) begin
                check("wr_mem_rw", mem_rw_data, 1);
                check("wr_mem_addr", mem_data_addr, 28'h0000010);
                check("wr_mem_wdata", mem_data_wr, 32'hA5A5A5A5);
            end
        end
        cyc();
        check("wr_cycB_mem_valid", mem_valid_data, 1);
        finish_txn(0, 32'h0BADF00D);
        req0_valid = 0;
        mid();
        check("wr_turn_mem_valid", mem_valid_data, 0);
        check("wr_turn_busy", busy, 0);
        check("wr_error", error, 3'b000);
        cyc();
        mid();
        check("wr_stay_idle", mem_valid_data, 0);

        // Both requesters continuously valid: strict alternation.
        reset_dut();
        req0_valid = 1; req0_addr = 28'h0000100;
        req1_valid = 1; req1_addr = 28'h0000200;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mid();
            check("rr_grant_id", grant_id, i % 2);
            check("rr_mem_addr", mem_data_addr, (i % 2) ? 28'h0000200 : 28'h0000100);
            check("rr_mem_valid", mem_valid_data, 1);
            cyc();
            cyc();
            finish_txn(1'(i % 2), (i % 2) ? 32'h12345678 : 32'hCAFE0000 + 32'(i));
            mid();
            check("rr_turnaround", busy, 0);
        end
        req0_valid = 0; req1_valid = 0;

        // Timeout after 8 GRANT cycles, late completion, then clear.
        reset_dut();
        req0_valid = 1; req0_addr = 28'h0000300;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            mid();
            check("to_pre_error", error, 3'b000);
        end
        cyc();
        mid();
        check("to_error", error, 3'b001);
        check("to_mem_valid", mem_valid_data, 1);
        cyc();
        cyc();
        finish_txn(0, 32'h55AA55AA);
        req0_valid = 0;
        mid();
        check("to_done_busy", busy, 0);
        check("to_sticky", error, 3'b001);
        cyc();
        err_clr = 1;
        mid();
        cyc();
        err_clr = 0;
        mid();
        check("to_cleared", error, 3'b000);

        // Abandon by req1, then a spurious ready while idle.
        reset_dut();
        req1_valid = 1; req1_rw = 1; req1_addr = 28'h0000400; req1_wdata = 32'h11112222;
        cyc();
        mid();
        check("ab_grant_id", grant_id, 1);
        check("ab_busy", busy, 1);
        cyc();
        req1_valid = 0;
        mid();
        check("ab_pre_error", error, 3'b000);
        cyc();
        mid();
        check("ab_error", error, 3'b010);
        check("ab_mem_valid", mem_valid_data, 1);
        check("ab_mem_addr", mem_data_addr, 28'h0000400);
        cyc();
        finish_txn(1, 32'h77778888);
        mid();
        check("ab_done_busy", busy, 0);
        cyc();
        mem_ready_data = 1;
        mid();
        check("sp_no_ready", {req0_ready, req1_ready}, 2'b00);
        cyc();
        mem_ready_data = 0;
        mid();
        check("sp_error", error, 3'b110);
        cyc();
        mid();
        check("sp_sticky", error, 3'b110);

        // Reset mid-GRANT1 after the pointer has moved to req1.
        reset_dut();
        req0_valid = 1; req0_addr = 28'h0000500;
        req1_valid = 1; req1_addr = 28'h0000600;
        cyc();
        mid();
        check("mr_first_grant", grant_id, 0);
        cyc();
        finish_txn(0, 32'h00000001);
        req0_valid = 0;
        cyc();
        mid();
        check("mr_grant1", grant_id, 1);
        check("mr_busy", busy, 1);
        rst = 0;
        #1;
        check("mr_mem_valid", mem_valid_data, 0);
        check("mr_busy_rst", busy, 0);
        check("mr_grant_id_rst", grant_id, 0);
        cyc();
        req0_valid = 1;
        rst = 1;
        cyc();
        mid();
        check("mr_rr_reset", grant_id, 0);
        check("mr_addr", mem_data_addr, 28'h0000500);
        cyc();
        finish_txn(0, 32'h00000002);
        req0_valid = 0; req1_valid = 0;
        mid();

        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
